machine_timer: RTL and testbench
================================

// Module: machine_timer
// PURPOSE
//  Memory-mapped RISC-V machine timer: 64-bit mtime counter and mtimecmp compare register.
//  Produces the machine timer interrupt pending level (timer_interrupt) consumed by the CSR file as mip.MTIP.
//  Sits on the core data bus as a slave; one outstanding request, single-word (32-bit) accesses.
// PARAMETERS
//  TICK_DIVIDE  1   clock cycles per mtime increment; legal range 1..65535; 1 = increment every cycle
// PORTS
//  clock            in   1   sole clock; all state updates on posedge
//  reset            in   1   asynchronous, active-high reset
//  bus_valid        in   1   request present; held with address/data until bus_ready
//  bus_write        in   1   1 = write, 0 = read; qualified by bus_valid
//  bus_address      in   3   word select: 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 msip
//  bus_write_data   in   32  write data
//  bus_read_data    out  32  read data; valid while bus_ready=1 on a read
//  bus_ready        out  1   one-cycle completion pulse
//  timer_interrupt  out  1   registered (mtime >= mtimecmp), unsigned 64-bit compare
//  software_interrupt out 1  msip bit (see CONFIGURATION)
// BEHAVIOUR
//  Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, hi_shadow=0, msip=0,
//   bus_ready=0, bus_read_data=0, timer_interrupt=0, software_interrupt=0. Async assert, sync-use deassert.
//  Prescaler: counts 0..TICK_DIVIDE-1; tick asserted on cycle it equals TICK_DIVIDE-1, then wraps to 0.
//  mtime: +1 on tick; wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0. Carry from low to high word is internal, same cycle.
//  Handshake: bus_valid sampled when bus_ready=0 -> access performed that edge, bus_ready=1 next cycle
//   (latency 1). Cycle with bus_ready=1 never accepts a new request; back-to-back throughput 1 per 2 cycles.
//  Read: bus_read_data registered at acceptance. Read of address 0 returns mtime[31:0] and captures
//   mtime[63:32] into hi_shadow same edge; read of address 1 returns hi_shadow (not live value).
//   Addresses 2,3 return mtimecmp halves; 4 returns {31'b0,msip}; 5..7 return 0.
//  Write: addr 0/1 replace that mtime half; addr 2/3 replace that mtimecmp half; 5..7 ignored, still ready.
//  Write vs tick same cycle: written half takes write value exactly; no increment applied that cycle to
//   either half (prescaler still advances). Other half unchanged.
//  timer_interrupt: registered from post-update mtime/mtimecmp; follows changes 1 cycle after the edge
//   that changed them. Level, not sticky: clears when mtimecmp rewritten above mtime or mtime wraps.
//  Reset mid-transaction: pending bus_ready dropped; master must re-issue.
// CONFIGURATION
//  MACHINE_TIMER_MSIP_EN defined: address 4 is a read/write msip register (bit0 of write data);
//   software_interrupt = msip, registered.
//  Not defined: address 4 reads 0, writes ignored, software_interrupt tied 0. All other behaviour identical.
// TESTING
//  Reset, TICK_DIVIDE=1, idle 10 cycles -> read addr0 returns 10 (+/- access latency fixed at 11), timer_interrupt=0.
//  Write mtime lo=32'hFFFF_FFFF, hi=0; read lo/hi after carry -> hi_shadow=1, lo small, hi consistent with lo snapshot.
//  Write mtimecmp={0,20} with mtime=0 -> timer_interrupt rises exactly 1 cycle after mtime reaches 20;
//   then write mtimecmp hi=1 -> timer_interrupt falls 1 cycle after write edge.
//  TICK_DIVIDE=4: 40 cycles after reset mtime=10; write addr0 on a tick cycle -> value equals write data exactly.
//  mtime=64'hFFFF_FFFF_FFFF_FFFF, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF -> interrupt=1; one tick later mtime=0, interrupt=0.
//  With MACHINE_TIMER_MSIP_EN: write addr4=1 -> software_interrupt=1, read addr4=1; without: read 0, output 0.

Source files
------------

// File: rtl/machine_timer.sv
// RISC-V machine timer slave: 64-bit mtime/mtimecmp with a registered timer interrupt.
// Define MACHINE_TIMER_MSIP_EN to make address 4 a read/write msip register.
module machine_timer #(
  parameter int unsigned TICK_DIVIDE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [2:0]  bus_address,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        bus_ready,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  typedef enum logic [2:0] {
    ADDR_MTIME_LO = 3'd0,
    ADDR_MTIME_HI = 3'd1,
    ADDR_CMP_LO   = 3'd2,
    ADDR_CMP_HI   = 3'd3,
    ADDR_MSIP     = 3'd4
  } addr_e;

  logic [15:0] prescaler;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow;
  logic        msip;
  logic        tick;
  logic        accept;
  logic        rd_en;
  logic        wr_en;
  addr_e       sel;
  logic [31:0] read_value;

  always_comb begin
    tick   = (prescaler == 16'(TICK_DIVIDE - 1));
    accept = bus_valid & ~bus_ready;
    rd_en  = accept & ~bus_write;
    wr_en  = accept & bus_write;
    sel    = addr_e'(bus_address);
  end

  always_comb begin
    read_value = '0;
    case (sel)
      ADDR_MTIME_LO: read_value = mtime[31:0];
      ADDR_MTIME_HI: read_value = hi_shadow;
      ADDR_CMP_LO:   read_value = mtimecmp[31:0];
      ADDR_CMP_HI:   read_value = mtimecmp[63:32];
      ADDR_MSIP:     read_value = {31'b0, msip};
      default:       read_value = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler       <= '0;
      mtime           <= '0;
      mtimecmp        <= '1;
      hi_shadow       <= '0;
      bus_ready       <= 1'b0;
      bus_read_data   <= '0;
      timer_interrupt <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 16'd1;
      bus_ready <= accept;
      if (rd_en) begin
        bus_read_data <= read_value;
        // Snapshot the high word so a lo-then-hi read pair is coherent.
        if (sel == ADDR_MTIME_LO) hi_shadow <= mtime[63:32];
      end
      // A write to either mtime half suppresses that cycle's increment entirely.
      if (wr_en && sel == ADDR_MTIME_LO)      mtime[31:0]  <= bus_write_data;
      else if (wr_en && sel == ADDR_MTIME_HI) mtime[63:32] <= bus_write_data;
      else if (tick)                          mtime        <= mtime + 64'd1;
      if (wr_en && sel == ADDR_CMP_LO) mtimecmp[31:0]  <= bus_write_data;
      if (wr_en && sel == ADDR_CMP_HI) mtimecmp[63:32] <= bus_write_data;
      timer_interrupt <= (mtime >= mtimecmp);
    end
  end

`ifdef MACHINE_TIMER_MSIP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              msip <= 1'b0;
    else if (wr_en && sel == ADDR_MSIP)     msip <= bus_write_data[0];
  end
  assign software_interrupt = msip;
`else
  assign msip               = 1'b0;
  assign software_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_machine_timer.sv
// Randomized bench for machine_timer: two instances (divide 1 and 4) against a per-edge arithmetic model.
module tb_machine_timer;

  localparam int unsigned DIV0 = 1;
  localparam int unsigned DIV1 = 4;
  localparam bit MSIP_EN =
`ifdef MACHINE_TIMER_MSIP_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid0 = 1'b0;
  logic        valid1 = 1'b0;
  logic        bus_write = 1'b0;
  logic [2:0]  bus_address = '0;
  logic [31:0] bus_write_data = '0;
  logic [31:0] rd0, rd1;
  logic        ready0, ready1, ti0, ti1, si0, si1;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [63:0] m_time [2];
  logic [63:0] m_cmp [2];
  logic [31:0] m_shadow [2];
  logic [31:0] m_rd [2];
  logic        m_msip [2];
  logic        m_irq [2];
  logic        m_ready [2];
  longint unsigned edges;
  bit          acc_valid = 1'b0;
  int          acc_sel = 0;

  machine_timer #(.TICK_DIVIDE(DIV0)) dut0 (
    .clock(clock), .reset(reset), .bus_valid(valid0), .bus_write(bus_write),
    .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_read_data(rd0),
    .bus_ready(ready0), .timer_interrupt(ti0), .software_interrupt(si0));

  machine_timer #(.TICK_DIVIDE(DIV1)) dut1 (
    .clock(clock), .reset(reset), .bus_valid(valid1), .bus_write(bus_write),
    .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_read_data(rd1),
    .bus_ready(ready1), .timer_interrupt(ti1), .software_interrupt(si1));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_time[i] = '0; m_cmp[i] = '1; m_shadow[i] = '0; m_rd[i] = '0;
      m_msip[i] = 1'b0; m_irq[i] = 1'b0; m_ready[i] = 1'b0;
    end
    edges = 0;
  endtask

  // mtime advances on edge k when k mod divide == divide-1, counting edges since reset release.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int unsigned div;
      bit tick, acc;
      logic [63:0] t, c;
      div  = (i == 0) ? DIV0 : DIV1;
      tick = (edges % div) == longint'(div - 1);
      acc  = acc_valid && (acc_sel == i);
      t = m_time[i];
      c = m_cmp[i];
      m_irq[i]   = (t >= c);
      m_ready[i] = acc;
      if (acc && !bus_write) begin
        case (bus_address)
          3'd0: m_rd[i] = t[31:0];
          3'd1: m_rd[i] = m_shadow[i];
          3'd2: m_rd[i] = c[31:0];
          3'd3: m_rd[i] = c[63:32];
          3'd4: m_rd[i] = MSIP_EN ? {31'b0, m_msip[i]} : 32'd0;
          default: m_rd[i] = 32'd0;
        endcase
        if (bus_address == 3'd0) m_shadow[i] = t[63:32];
      end
      if (acc && bus_write) begin
        case (bus_address)
          3'd0: t[31:0]  = bus_write_data;
          3'd1: t[63:32] = bus_write_data;
          3'd2: c[31:0]  = bus_write_data;
          3'd3: c[63:32] = bus_write_data;
          3'd4: if (MSIP_EN) m_msip[i] = bus_write_data[0];
          default: ;
        endcase
      end
      if (!(acc && bus_write && bus_address <= 3'd1) && tick) t = t + 64'd1;
      m_time[i] = t;
      m_cmp[i]  = c;
    end
    edges++;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("ready0", ready0, m_ready[0]);
    check("ready1", ready1, m_ready[1]);
    check("irq0", ti0, m_irq[0]);
    check("irq1", ti1, m_irq[1]);
    check("sirq0", si0, m_msip[0]);
    check("sirq1", si1, m_msip[1]);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  // Valid is held through the ready cycle to confirm that cycle does not accept.
  task automatic access(input int sel, input bit wr, input logic [2:0] a,
                        input logic [31:0] d, output logic [31:0] rdata);
    bus_write = wr; bus_address = a; bus_write_data = d;
    if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
    acc_valid = 1'b1; acc_sel = sel;
    step();
    acc_valid = 1'b0;
    rdata = (sel == 0) ? rd0 : rd1;
    if (!wr) check((sel == 0) ? "rdata0" : "rdata1", rdata, m_rd[sel]);
    step();
    valid0 = 1'b0; valid1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; acc_valid = 1'b0;
    @(posedge clock); #1;
    check("rst_rdata", {rd1, rd0}, 64'd0);
    check("rst_ready", {ready1, ready0}, 64'd0);
    check("rst_irq", {ti1, ti0}, 64'd0);
    check("rst_sirq", {si1, si0}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  logic [31:0] r;
  logic [31:0] d;

  initial begin
    model_reset();
    do_reset();

    idle(10);
    access(0, 1'b0, 3'd0, 32'd0, r);
    check("idle10_lo", r, 32'd10);
    access(1, 1'b0, 3'd0, 32'd0, r);

    // Low-word carry and coherent hi snapshot.
    for (int s = 0; s < 2; s++) begin
      access(s, 1'b1, 3'd1, 32'd0, r);
      access(s, 1'b1, 3'd0, 32'hFFFF_FFF0, r);
      idle(70);
      access(s, 1'b0, 3'd0, 32'd0, r);
      access(s, 1'b0, 3'd1, 32'd0, r);
      check("carry_hi", r, 32'd1);
    end

    // Compare at 20, then raise mtimecmp above mtime.
    do_reset();
    access(0, 1'b1, 3'd2, 32'd20, r);
    access(0, 1'b1, 3'd3, 32'd0, r);
    access(0, 1'b1, 3'd0, 32'd0, r);
    idle(30);
    check("irq_after20", ti0, 1'b1);
    access(0, 1'b1, 3'd3, 32'd1, r);
    idle(2);
    check("irq_cleared", ti0, 1'b0);

    // Wrap at all-ones with mtimecmp all-ones.
    for (int s = 0; s < 2; s++) begin
      access(s, 1'b1, 3'd3, 32'hFFFF_FFFF, r);
      access(s, 1'b1, 3'd2, 32'hFFFF_FFFF, r);
      access(s, 1'b1, 3'd1, 32'hFFFF_FFFF, r);
      access(s, 1'b1, 3'd0, 32'hFFFF_FFFF, r);
      idle(12);
    end

    // Divide-4 write landing on a tick edge must keep the written value exactly.
    do_reset();
    idle(40);
    access(1, 1'b0, 3'd0, 32'd0, r);
    check("div4_40", r, 32'd10);
    while ((edges % DIV1) != longint'(DIV1 - 1)) step();
    access(1, 1'b1, 3'd0, 32'h1234_5678, r);
    access(1, 1'b0, 3'd0, 32'd0, r);
    check("tick_write", r, 32'h1234_5678);

    // Software interrupt register.
    for (int s = 0; s < 2; s++) begin
      access(s, 1'b1, 3'd4, 32'd1, r);
      idle(1);
      access(s, 1'b0, 3'd4, 32'd0, r);
      check("msip_read", r, MSIP_EN ? 32'd1 : 32'd0);
    end

    // Reset while bus_ready is pending drops it asynchronously.
    bus_write = 1'b0; bus_address = 3'd2; valid0 = 1'b1;
    acc_valid = 1'b1; acc_sel = 0;
    step();
    acc_valid = 1'b0;
    #2 reset = 1'b1; valid0 = 1'b0;
    #1 check("rst_mid_ready", ready0, 1'b0);
    do_reset();

    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [2:0] a;
      sel = int'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: idle($urandom_range(0, 6));
        1: access(sel, 1'b0, a, 32'd0, r);
        default: begin
          case (a)
            3'd0: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 100));
            3'd1: d = 32'($urandom_range(0, 1));
            3'd2: d = m_time[sel][31:0] + 32'($urandom_range(0, 60)) - 32'd30;
            3'd3: d = m_time[sel][63:32] + 32'($urandom_range(0, 1));
            default: d = $urandom;
          endcase
          access(sel, 1'b1, a, d, r);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
